// File: rtl/button_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_ctrl_pkg
// Brief    : Register offsets and counter-width helper for the key peripheral.
// Revision : 1.0
// ============================================================================
package button_ctrl_pkg;

  localparam logic [1:0] BTN_STATE   = 2'd0;
  localparam logic [1:0] BTN_PRESS   = 2'd1;
  localparam logic [1:0] BTN_RELEASE = 2'd2;
  localparam logic [1:0] BTN_IEN     = 2'd3;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int unsigned btn_clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if (((value - 1) >> i) != 0) width = i + 1;
    end
    return width;
  endfunction

endpackage : button_ctrl_pkg
`default_nettype wire

// File: rtl/button_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Single key channel: 2-flop synchroniser, debounce, edge pulses.
// Revision : 1.0
// ============================================================================
module key_debounce
  import button_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = btn_clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = key_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    fall     = 1'b0;
    // Any sample agreeing with the accepted level restarts the count.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise     = sync2_q;
      fall     = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_ctrl
// Brief    : Debounced key inputs with W1C press/release flags and press irq.
// Revision : 1.0
// ============================================================================
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int unsigned N_KEYS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] user_key,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq
);

  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] fall;

  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] ien_q, ien_d;
  logic [N_KEYS-1:0] clr_press;
  logic [N_KEYS-1:0] clr_release;
  logic              unused_wdata;

  // Inverting ahead of the synchroniser keeps all internal state 1 = pressed.
  assign key_in = ACTIVE_LOW ? ~user_key : user_key;

  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk   (clk),
      .reset (reset),
      .key_in(key_in[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  always_comb begin
    clr_press   = (we && addr == BTN_PRESS)   ? wdata[N_KEYS-1:0] : '0;
    clr_release = (we && addr == BTN_RELEASE) ? wdata[N_KEYS-1:0] : '0;
    // A hardware event on the same edge as its clear keeps the flag set.
    press_d     = (press_q & ~clr_press) | rise;
    release_d   = (release_q & ~clr_release) | fall;
    ien_d       = (we && addr == BTN_IEN) ? wdata[N_KEYS-1:0] : ien_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
      ien_q     <= '0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      ien_q     <= ien_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      BTN_STATE:   rdata[N_KEYS-1:0] = stable;
      BTN_PRESS:   rdata[N_KEYS-1:0] = press_q;
      BTN_RELEASE: rdata[N_KEYS-1:0] = release_q;
      BTN_IEN:     rdata[N_KEYS-1:0] = ien_q;
      default:     rdata = '0;
    endcase
  end

  assign irq = |(press_q & ien_q);

  assign unused_wdata = ^wdata;

endmodule : button_ctrl
`default_nettype wire
